gand16: RTL and testbench
=========================

Name: gand16

Overview:
- Registered 16-bit bitwise AND gate with valid qualification and result status flags.
- Computes y = a & b, one clock cycle after inputs are accepted. Also reports zero, all-ones and population count of the result.
- Used as a datapath primitive in the gate-library blocks. Downstream logic samples y and the flags when out_valid is high.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 1.
- CNT_W, $clog2(WIDTH+1), width of the popcount output (5 for WIDTH=16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a and b are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  registered result, a & b.
- out_valid  output  1  y and the flags hold a freshly computed result.
- zero  output  1  registered flag, set when y is 0.
- ones  output  1  registered flag, set when y has every bit set.
- popcnt  output  CNT_W  registered number of set bits in y.

Behaviour:
- Reset is sampled only on the rising edge of clk while rst=1.
  - During reset: y=0, out_valid=0, zero=1, ones=0, popcnt=0.
  - Reset takes priority over in_valid in the same cycle; an operand pair presented during reset is discarded.
- Compute edge: at each rising edge with rst=0 and in_valid=1:
  - y <= a & b, bit i of y = a[i] AND b[i], no carries or cross-bit interaction.
  - zero <= (a & b) == 0.
  - ones <= (a & b) == all ones.
  - popcnt <= number of set bits in (a & b), range 0..WIDTH.
  - out_valid <= 1.
- Hold edge: at each rising edge with rst=0 and in_valid=0:
  - y, zero, ones and popcnt keep their previous values.
  - out_valid <= 0.
- Latency is exactly 1 cycle from accepting the operands to out_valid=1 with the matching result.
- Throughput is one result per cycle. Back-to-back in_valid pulses produce a continuous out_valid.
- There is no backpressure and no ready signal; the output is overwritten on every compute edge.
- Flags are derived from the same combinational AND as y, so they are always consistent with y in the same cycle.
- Inputs with X/Z values are outside the specification. Operands are sampled only on compute edges.
- Reset asserted mid-stream clears everything on the next edge. The first in_valid after reset deasserts produces a result one cycle later.
- Fully synchronous, no latches. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a=16'hFFFF, b=16'hFFFF, in_valid=1 -> y=0, out_valid=0, zero=1, ones=0, popcnt=0.
- Basic compute: a=16'h3524, b=16'h5E81, in_valid=1 for one cycle -> next cycle y=16'h1400, popcnt=2, zero=0, ones=0, out_valid=1. The following idle cycle -> out_valid=0 and y still 16'h1400.
- Back-to-back stream: a=16'hD609/b=16'h5663 then a=16'hFFFF/b=16'hFFFF on consecutive cycles:
  - first result: y=16'h5601, popcnt=5;
  - second result: y=16'hFFFF, ones=1, popcnt=16;
  - out_valid high for both cycles.
- Zero result: a=16'hAAAA, b=16'h5555, in_valid=1 -> y=0, zero=1, popcnt=0, out_valid=1.
- Reset mid-operation: in_valid=1 with a=b=16'h00FF in the same cycle as rst=1 -> next cycle y=0, out_valid=0. After deassert, a=b=16'h00FF with in_valid=1 -> y=16'h00FF, popcnt=8.
- Randomized check: 1000 random cycles with random in_valid, a and b -> y, zero, ones and popcnt match a 1-cycle-delayed reference model; values hold whenever in_valid=0.

Source files
------------

// File: rtl/gand16.sv
// gand16: registered bitwise AND of two operands, with zero / all-ones /
// population-count status flags computed from the same AND term.
//
// Handshake: in_valid qualifies a and b for exactly the cycle it is high.
// There is no ready, and the block never stalls. Every accepted pair yields
// out_valid=1 on the next cycle. y and the flags hold their last values while
// out_valid=0, and each new result overwrites them.
module gand16 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   output logic             zero,
   output logic             ones,
   output logic [CNT_W-1:0] popcnt
);

   logic [WIDTH-1:0] and_w;
   logic [CNT_W-1:0] pop_w;

   // One shared AND term feeds the result and every flag, so they always agree
   assign and_w = a & b;

   // Count the set bits of the AND term
   always_comb begin
      pop_w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_w = pop_w + CNT_W'(and_w[i]);
      end
   end

   // Capture the result on compute edges. Outside those edges, hold it and
   // drop out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         y         <= '0;
         out_valid <= 1'b0;
         zero      <= 1'b1;
         ones      <= 1'b0;
         popcnt    <= '0;
      end else if (in_valid) begin
         y         <= and_w;
         out_valid <= 1'b1;
         zero      <= ~|and_w;
         ones      <= &and_w;
         popcnt    <= pop_w;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gand16.sv
// tb_gand16: directed checks of gand16, followed by a seeded random run that
// is compared against a behavioural reference model.
module tb_gand16;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             zero;
   logic             ones;
   logic [CNT_W-1:0] popcnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] exp_q[$];

   gand16 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .y         (y),
      .out_valid (out_valid),
      .zero      (zero),
      .ones      (ones),
      .popcnt    (popcnt)
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then let the edge pass and settle.
   task automatic step(input logic r, input logic iv,
                       input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      rst      = r;
      in_valid = iv;
      a        = va;
      b        = vb;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Check all five outputs at once.
   task automatic check_all(input string tag, input logic [WIDTH-1:0] ey,
                            input logic eov, input logic ez, input logic eo,
                            input logic [CNT_W-1:0] ep);
      check({tag, ".y"},         y,                 ey);
      check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, eov});
      check({tag, ".zero"},      {15'd0, zero},     {15'd0, ez});
      check({tag, ".ones"},      {15'd0, ones},     {15'd0, eo});
      check({tag, ".popcnt"},    {11'd0, popcnt},   {11'd0, ep});
   endtask

   // Reference popcount. It clears the lowest set bit on each pass.
   function automatic int ref_pop(input logic [WIDTH-1:0] v);
      int n = 0;
      logic [WIDTH-1:0] t = v;
      while (t != 0) begin
         t = t & (t - 1'b1);
         n++;
      end
      return n;
   endfunction

   initial begin
      logic             iv;
      logic [WIDTH-1:0] ra, rb, ey, last_y;
      logic             ez, eo;
      logic [CNT_W-1:0] ep;
      logic             had_result;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

      // Reset with live operands present; they must be discarded
      step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
      step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
      check_all("reset", 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0);

      // Basic compute, then an idle cycle that holds the result
      step(1'b0, 1'b1, 16'h3524, 16'h5E81);
      check_all("basic", 16'h1400, 1'b1, 1'b0, 1'b0, 5'd2);
      step(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
      check_all("basic_hold", 16'h1400, 1'b0, 1'b0, 1'b0, 5'd2);

      // Back-to-back stream
      step(1'b0, 1'b1, 16'hD609, 16'h5663);
      check_all("b2b_0", 16'h5601, 1'b1, 1'b0, 1'b0, 5'd5);
      step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
      check_all("b2b_1", 16'hFFFF, 1'b1, 1'b0, 1'b1, 5'd16);

      // Disjoint operands give a zero result
      step(1'b0, 1'b1, 16'hAAAA, 16'h5555);
      check_all("zero_res", 16'h0000, 1'b1, 1'b1, 1'b0, 5'd0);

      // Single-bit overlap at the MSB
      step(1'b0, 1'b1, 16'h8001, 16'hF000);
      check_all("msb_bit", 16'h8000, 1'b1, 1'b0, 1'b0, 5'd1);

      // Reset wins over in_valid, and the next operand pair computes normally
      step(1'b1, 1'b1, 16'h00FF, 16'h00FF);
      check_all("mid_reset", 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0);
      step(1'b0, 1'b1, 16'h00FF, 16'h00FF);
      check_all("after_reset", 16'h00FF, 1'b1, 1'b0, 1'b0, 5'd8);

      // Random run against the reference model
      last_y     = 16'h00FF;
      had_result = 1'b1;
      ez = 1'b0; eo = 1'b0; ep = 5'd8;
      for (int i = 0; i < 1000; i++) begin
         iv = ($urandom_range(0, 3) != 0);
         ra = WIDTH'($urandom_range(0, 16'hFFFF));
         rb = WIDTH'($urandom_range(0, 16'hFFFF));
         if ($urandom_range(0, 15) == 0) rb = ~ra;
         if ($urandom_range(0, 15) == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; end
         if (iv) exp_q.push_back(ra & rb);
         step(1'b0, iv, ra, rb);
         if (iv) begin
            ey = exp_q.pop_front();
            last_y = ey;
            ez = (ey == 16'h0000);
            eo = (ey == 16'hFFFF);
            ep = CNT_W'(ref_pop(ey));
         end
         check_all("rand", last_y, iv, ez, eo, ep);
      end
      check("rand.queue_empty", 16'(exp_q.size()), 16'd0);
      if (!had_result) n_fail++;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
